key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 23 ++
 rtl/key_debounce_ch.sv | 166 ++++++++++++++++
 rtl/key_debounce.sv | 58 +++++
 tb/tb_key_debounce.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the push-button debounce stage.
//   - key_state_t : per-channel debounce FSM state encoding
//                   (IDLE=0, PRESS_CHK=1, HELD=2, REL_CHK=3)
//   - ms_to_cyc() : converts a time in milliseconds to clock cycles
// -----------------------------------------------------------------------------
package key_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } key_state_t;

   // Divide first so large clock rates do not overflow 32-bit arithmetic.
   function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                             input int unsigned ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One debounced push-button channel: 2-flop synchroniser, 4-state debounce
//   FSM with a saturating debounce counter, and an optional hold counter that
//   produces a single long-press pulse.
//
//   Optional feature macro: KEY_DEBOUNCE_LONGPRESS_EN
//     defined   : hold counter built, key_long pulses once per long hold
//     undefined : no hold counter, key_long tied 0
//
//   Parameters
//     DB_CYC   : stable cycles needed to accept an edge (>= 2)
//     LONG_CYC : hold cycles (after accepted press) for key_long
//
//   Ports
//     CLK_50MHz   in  : system clock
//     Reset_n     in  : synchronous active-low reset
//     key_n       in  : raw button, asynchronous, 0 = pressed
//     key_level   out : debounced level, 1 = pressed
//     key_press   out : 1-cycle pulse on accepted press
//     key_release out : 1-cycle pulse on accepted release
//     key_long    out : 1-cycle pulse on long press
// -----------------------------------------------------------------------------
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DB_CYC   = 1_000_000,
   parameter int unsigned LONG_CYC = 50_000_000
) (
   input  logic CLK_50MHz,
   input  logic Reset_n,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned     DB_W    = $clog2(DB_CYC);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

   // ---------------------------------------------------------------- sync
   logic [1:0] sync;
   logic       s;

   // Reset to the released level so no press is seen straight after reset.
   always_ff @(posedge CLK_50MHz) begin
      if (!Reset_n) begin
         sync <= '1;
      end else begin
         sync <= {sync[0], key_n};
      end
   end

   assign s = ~sync[1];

   // ----------------------------------------------------------------- FSM
   key_state_t      state, state_nxt;
   logic [DB_W-1:0] db_cnt, db_cnt_nxt;
   logic            level_nxt, press_nxt, release_nxt;

   always_ff @(posedge CLK_50MHz) begin
      if (!Reset_n) begin
         state       <= IDLE;
         db_cnt      <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         state       <= state_nxt;
         db_cnt      <= db_cnt_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
      end
   end

   // The debounce counter only advances while below DB_LAST; reaching DB_LAST
   // with a confirming sample always leaves the check state, so it saturates.
   always_comb begin
      state_nxt   = state;
      db_cnt_nxt  = db_cnt;
      level_nxt   = key_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (s) begin
               state_nxt  = PRESS_CHK;
               db_cnt_nxt = '0;
            end
         end
         PRESS_CHK: begin
            if (!s) begin
               state_nxt = IDLE;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = HELD;
               press_nxt = 1'b1;
               level_nxt = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!s) begin
               state_nxt  = REL_CHK;
               db_cnt_nxt = '0;
            end
         end
         REL_CHK: begin
            if (s) begin
               state_nxt = HELD;
            end else if (db_cnt == DB_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               level_nxt   = 1'b0;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------- long press
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
   localparam int unsigned       HOLD_W    = $clog2(LONG_CYC + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);

   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              long_nxt;

   always_ff @(posedge CLK_50MHz) begin
      if (!Reset_n) begin
         hold_cnt <= '0;
         key_long <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
         key_long <= long_nxt;
      end
   end

   // Counter runs one step past HOLD_LAST to HOLD_SAT and parks there, so the
   // pulse fires exactly once per hold; a bounce back to HELD keeps the count.
   always_comb begin
      hold_cnt_nxt = hold_cnt;
      long_nxt     = 1'b0;
      if (state == HELD || state == REL_CHK) begin
         long_nxt = (hold_cnt == HOLD_LAST);
         if (hold_cnt != HOLD_SAT) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
         end
      end
      if (state_nxt == IDLE || (state == PRESS_CHK && state_nxt == HELD)) begin
         hold_cnt_nxt = '0;
      end
   end
`else
   // Expression keeps LONG_CYC referenced; it always evaluates to 0.
   assign key_long = (LONG_CYC == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Input stage for the board LED sequencer: synchronises and debounces
//   NUM_KEYS active-low push buttons, each in an independent channel.
//
//   Optional feature macro: KEY_DEBOUNCE_LONGPRESS_EN (long-press pulses).
//
//   Parameters
//     NUM_KEYS    : number of button channels
//     CLK_HZ      : clock frequency
//     DEBOUNCE_MS : stable time to accept an edge (DB_CYC must be >= 2)
//     LONG_MS     : hold time for a long-press event
//
//   Ports
//     CLK_50MHz   in              : system clock
//     Reset_n     in              : synchronous active-low reset
//     key_n       in  [NUM_KEYS]  : raw buttons, 0 = pressed
//     key_level   out [NUM_KEYS]  : debounced level, 1 = pressed
//     key_press   out [NUM_KEYS]  : 1-cycle accepted-press pulse
//     key_release out [NUM_KEYS]  : 1-cycle accepted-release pulse
//     key_long    out [NUM_KEYS]  : 1-cycle long-press pulse (0 if disabled)
// -----------------------------------------------------------------------------
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS    = 4,
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000
) (
   input  logic                CLK_50MHz,
   input  logic                Reset_n,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   localparam int unsigned DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_ch #(
         .DB_CYC   (DB_CYC),
         .LONG_CYC (LONG_CYC)
      ) u_ch (
         .CLK_50MHz   (CLK_50MHz),
         .Reset_n     (Reset_n),
         .key_n       (key_n[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Self-checking bench for key_debounce with CLK_HZ=1000, DEBOUNCE_MS=4
//   (DB_CYC=4), LONG_MS=20 (LONG_CYC=20). Honours KEY_DEBOUNCE_LONGPRESS_EN.
//   The reference model accepts an edge once the last DB_CYC+1 synchronised
//   samples all disagree with the accepted level.
// -----------------------------------------------------------------------------
module tb_key_debounce;

   localparam int NK       = 4;
   localparam int DB_CYC   = 4;
   localparam int LONG_CYC = 20;
   localparam int LAT      = DB_CYC + 3;

   logic          clk = 1'b0;
   logic          Reset_n;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_level, key_press, key_release, key_long;

   key_debounce #(
      .NUM_KEYS    (NK),
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (20)
   ) dut (
      .CLK_50MHz   (clk),
      .Reset_n     (Reset_n),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   logic          m_p1 [NK];
   logic          m_p2 [NK];
   logic          m_lvl[NK];
   int            m_run [NK];
   int            m_held[NK];
   logic [NK-1:0] exp_level, exp_press, exp_release, exp_long;

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         m_p1[k] = 1'b1; m_p2[k] = 1'b1; m_lvl[k] = 1'b0;
         m_run[k] = 0;   m_held[k] = 0;
      end
      exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
   endtask

   // Predicts outputs after the next rising edge given the applied inputs.
   task automatic model_edge(input logic rst_n, input logic [NK-1:0] kn);
      logic s;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NK; k++) begin
         s = ~m_p2[k];
         m_p2[k] = m_p1[k];
         m_p1[k] = kn[k];
         exp_press[k] = 1'b0; exp_release[k] = 1'b0; exp_long[k] = 1'b0;
         if (m_lvl[k]) begin
            m_held[k]++;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
            if (m_held[k] == LONG_CYC) exp_long[k] = 1'b1;
`endif
         end
         m_run[k] = (s != m_lvl[k]) ? m_run[k] + 1 : 0;
         if (m_run[k] == DB_CYC + 1) begin
            if (m_lvl[k]) exp_release[k] = 1'b1;
            else begin
               exp_press[k] = 1'b1;
               m_held[k] = 0;
            end
            m_lvl[k] = ~m_lvl[k];
            m_run[k] = 0;
         end
         exp_level[k] = m_lvl[k];
      end
   endtask

   // Apply inputs at negedge, let one rising edge pass, compare at negedge.
   task automatic tick(input logic rst_n, input logic [NK-1:0] kn);
      Reset_n = rst_n;
      key_n   = kn;
      model_edge(rst_n, kn);
      @(posedge clk);
      @(negedge clk);
      check("level",   32'(key_level),   32'(exp_level));
      check("press",   32'(key_press),   32'(exp_press));
      check("release", 32'(key_release), 32'(exp_release));
      check("long",    32'(key_long),    32'(exp_long));
   endtask

   int            lat;
   int            cnt;
   logic [NK-1:0] kv;
   int            runlen[NK];

   initial begin
      Reset_n = 1'b0;
      key_n   = '1;
      model_reset();
      @(negedge clk);

      // Reset and quiet period
      repeat (3) tick(1'b0, '1);
      check("rst_level", 32'(key_level), 32'd0);
      repeat (50) tick(1'b1, '1);
      check("quiet_press", 32'(key_press), 32'd0);

      // Press latency on key 0
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick(1'b1, 4'b1110);
         if (lat < 0 && key_press[0]) lat = i;
      end
      check("press_lat", 32'(lat), 32'(LAT));
      check("held_level0", 32'(key_level[0]), 32'd1);

      // Release latency on key 0
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         tick(1'b1, '1);
         if (lat < 0 && key_release[0]) lat = i;
      end
      check("release_lat", 32'(lat), 32'(LAT));

      // Key 1 chatters every 2 cycles: no events
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, ((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111);
         cnt += int'(key_press[1]) + int'(key_release[1]);
      end
      repeat (10) tick(1'b1, '1);
      check("chatter_events", 32'(cnt), 32'd0);

      // Key 2 held 40 cycles: long press then release
      lat = -1; cnt = -1;
      for (int i = 1; i <= 40; i++) begin
         tick(1'b1, 4'b1011);
         if (key_press[2]) cnt = i;
         if (lat < 0 && key_long[2]) lat = i;
      end
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
      check("long_lat", 32'(lat - cnt), 32'(LONG_CYC));
`else
      check("long_off", 32'(lat), 32'hFFFF_FFFF);
`endif
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick(1'b1, '1);
         if (lat < 0 && key_release[2]) lat = i;
      end
      check("release2_lat", 32'(lat), 32'(LAT));

      // Keys 0 and 3 fall together
      cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         tick(1'b1, 4'b0110);
         if (key_press[0] && key_press[3]) cnt++;
      end
      check("simul_press", 32'(cnt), 32'd1);
      repeat (12) tick(1'b1, '1);

      // Reset while key 1 is held
      repeat (12) tick(1'b1, 4'b1101);
      tick(1'b0, 4'b1101);
      check("rst_drop", 32'(key_level), 32'd0);
      lat = -1;
      for (int i = 1; i <= 15; i++) begin
         tick(1'b1, 4'b1101);
         if (lat < 0 && key_press[1]) lat = i;
      end
      check("rst_repress_lat", 32'(lat), 32'(LAT));
      repeat (12) tick(1'b1, '1);

      // Randomised bouncing with occasional reset
      kv = '1;
      for (int k = 0; k < NK; k++) runlen[k] = $urandom_range(1, 12);
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NK; k++) begin
            runlen[k]--;
            if (runlen[k] <= 0) begin
               kv[k] = ~kv[k];
               runlen[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40)
                                                        : $urandom_range(1, 9);
            end
         end
         tick(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, kv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
